// File: rtl/types.sv
// Shared pipeline types: decoded-instruction record and ALU operation encodings.
package types;

  typedef struct packed {
    logic       is_valid;
    logic       is_load;
    logic       is_store;
    logic       wb_en;
    logic [4:0] rd;
  } InstructionDetails;

  localparam logic [3:0] FN_ADD   = 4'd0;
  localparam logic [3:0] FN_SUB   = 4'd1;
  localparam logic [3:0] FN_AND   = 4'd2;
  localparam logic [3:0] FN_OR    = 4'd3;
  localparam logic [3:0] FN_XOR   = 4'd4;
  localparam logic [3:0] FN_SHL   = 4'd5;
  localparam logic [3:0] FN_SHR   = 4'd6;
  localparam logic [3:0] FN_SRA   = 4'd7;
  localparam logic [3:0] FN_SLT   = 4'd8;
  localparam logic [3:0] FN_SLTU  = 4'd9;
  localparam logic [3:0] FN_AGEN  = 4'd10;
  localparam logic [3:0] FN_PASSB = 4'd11;
  localparam logic [3:0] FN_MUL   = 4'd12;
  localparam logic [3:0] FN_DIVU  = 4'd13;
  localparam logic [3:0] FN_REMU  = 4'd14;

endpackage

// File: rtl/execute_if.sv
// Execute-stage bus: instruction/operands in from decode, stall back, result out to memory stage.
interface execute_if;
  import types::*;

  InstructionDetails details;
  logic [3:0]        alu_fn;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic              flush;
  logic              stall;
  InstructionDetails out_details;
  logic [31:0]       data;

  modport master (output details, alu_fn, op_a, op_b, flush,
                  input  stall, out_details, data);
  modport slave  (input  details, alu_fn, op_a, op_b, flush,
                  output stall, out_details, data);
endinterface

// File: rtl/execute.sv
// Execute stage: single-cycle ALU plus a 32-step sequential MUL/DIVU/REMU unit
// that stalls upstream while it iterates.
module execute #(
  parameter int ITERS = 32
) (
  input logic     clk,
  input logic     rst_async_n,
  execute_if.slave bus
);
  import types::*;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam int CW = $clog2(ITERS);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [3:0]        fn_q, fn_d;
  InstructionDetails held_q, held_d;
  InstructionDetails out_q, out_d;
  logic [31:0]       data_q, data_d;
  logic              stall;
  logic              is_multi;
  logic [32:0]       div_shift, div_trial;

  function automatic logic [31:0] alu(input logic [3:0] fn, input logic [31:0] a,
                                      input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (fn)
      FN_ADD, FN_AGEN: alu = a + b;
      FN_SUB:          alu = a - b;
      FN_AND:          alu = a & b;
      FN_OR:           alu = a | b;
      FN_XOR:          alu = a ^ b;
      FN_SHL:          alu = a << b[4:0];
      FN_SHR:          alu = a >> b[4:0];
      FN_SRA:          alu = sa >>> b[4:0];
      FN_SLT:          alu = {31'd0, sa < sb};
      FN_SLTU:         alu = {31'd0, a < b};
      FN_PASSB:        alu = b;
      default:         alu = 32'd0;
    endcase
  endfunction

  assign is_multi = (bus.alu_fn == FN_MUL) || (bus.alu_fn == FN_DIVU) ||
                    (bus.alu_fn == FN_REMU);

  // Restoring division: remainder in acc_q, dividend shifts out of a_q as quotient bits shift in.
  assign div_shift = {acc_q, a_q[31]};
  assign div_trial = div_shift - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    fn_d    = fn_q;
    held_d  = held_q;
    data_d  = data_q;
    out_d   = '0;
    stall   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.details.is_valid) begin
          if (is_multi) begin
            stall   = 1'b1;
            acc_d   = '0;
            a_d     = bus.op_a;
            b_d     = bus.op_b;
            fn_d    = bus.alu_fn;
            held_d  = bus.details;
            cnt_d   = CW'(ITERS - 1);
            state_d = BUSY;
          end else begin
            data_d = alu(bus.alu_fn, bus.op_a, bus.op_b);
            out_d  = bus.details;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (fn_q == FN_MUL) begin
          if (a_q[0]) acc_d = acc_q + b_q;
          a_d = a_q >> 1;
          b_d = b_q << 1;
        end else if (!div_trial[32]) begin
          acc_d = div_trial[31:0];
          a_d   = {a_q[30:0], 1'b1};
        end else begin
          acc_d = div_shift[31:0];
          a_d   = {a_q[30:0], 1'b0};
        end
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        data_d  = (fn_q == FN_DIVU) ? a_q : acc_q;
        out_d   = held_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides any accept or completion decided above.
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      stall   = 1'b0;
      out_d   = '0;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    a_q    <= a_d;
    b_q    <= b_d;
    fn_q   <= fn_d;
    held_q <= held_d;
  end

  assign bus.stall       = stall;
  assign bus.out_details = out_q;
  assign bus.data        = data_q;

endmodule

// File: tb/tb_execute.sv
// Bench for the execute stage: directed vector table, multi-cycle corner sequences,
// and random operations against an arithmetic reference model.
module tb_execute;
  import types::*;

  logic clk = 1'b0;
  logic rst_async_n;
  int   checks = 0;
  int   failures = 0;
  int   rd_ctr = 1;

  execute_if bus();
  execute #(.ITERS(32)) dut (.clk(clk), .rst_async_n(rst_async_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] model(input logic [3:0] fn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    int sh;
    sa = a;
    sb = b;
    sh = int'(b % 32);
    case (fn)
      4'd0, 4'd10: return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return sa >>> sh;
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd11: return b;
      4'd12: return a * b;
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bubble();
    InstructionDetails d;
    d = '0;
    bus.details = d;
    bus.flush   = 1'b0;
  endtask

  task automatic present(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    InstructionDetails d;
    d          = '0;
    d.is_valid = 1'b1;
    d.wb_en    = 1'b1;
    d.rd       = 5'(rd_ctr);
    bus.details = d;
    bus.alu_fn  = fn;
    bus.op_a    = a;
    bus.op_b    = b;
    bus.flush   = 1'b0;
  endtask

  // Called mid-cycle (just after a rising edge); leaves the bench mid-cycle after the result.
  task automatic exec(input string name, input logic [3:0] fn, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    logic       multi;
    logic [4:0] rdv;
    int         bad_stall;
    int         bad_valid;
    rd_ctr = (rd_ctr % 31) + 1;
    rdv    = 5'(rd_ctr);
    present(fn, a, b);
    multi = (fn == 4'd12) || (fn == 4'd13) || (fn == 4'd14);
    #1;
    chk({name, "_stall_T"}, {31'd0, bus.stall}, {31'd0, multi});
    if (multi) begin
      bad_stall = 0;
      bad_valid = 0;
      for (int k = 1; k <= 33; k++) begin
        @(posedge clk); #1;
        if (bus.stall !== (k <= 32)) bad_stall++;
        if (bus.out_details.is_valid !== 1'b0) bad_valid++;
      end
      chk({name, "_stall_seq_errs"}, bad_stall, 0);
      chk({name, "_early_valid_errs"}, bad_valid, 0);
    end
    @(posedge clk); #1;
    chk({name, "_valid"}, {31'd0, bus.out_details.is_valid}, 32'd1);
    chk({name, "_data"}, bus.data, exp);
    chk({name, "_rd"}, {27'd0, bus.out_details.rd}, {27'd0, rdv});
    bubble();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    logic [3:0]  fn;
    logic [31:0] a, b;

    vecs.push_back('{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000});
    vecs.push_back('{4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF});
    vecs.push_back('{4'd7,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF});
    vecs.push_back('{4'd6,  32'h8000_0000, 32'd31,        32'h0000_0001});
    vecs.push_back('{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001});
    vecs.push_back('{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
    vecs.push_back('{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000});
    vecs.push_back('{4'd3,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0});
    vecs.push_back('{4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F});
    vecs.push_back('{4'd5,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002});
    vecs.push_back('{4'd10, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0FFC});
    vecs.push_back('{4'd11, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678});
    vecs.push_back('{4'd15, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000});
    vecs.push_back('{4'd12, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD});
    vecs.push_back('{4'd13, 32'd100,       32'd7,         32'd14});
    vecs.push_back('{4'd14, 32'd100,       32'd7,         32'd2});
    vecs.push_back('{4'd13, 32'hDEAD_BEEF, 32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{4'd14, 32'd5,         32'd0,         32'd5});

    bubble();
    bus.alu_fn = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    rst_async_n = 1'b1;
    #2 rst_async_n = 1'b0;
    #1;
    chk("reset_data", bus.data, 32'd0);
    chk("reset_details", {23'd0, bus.out_details}, 32'd0);
    chk("reset_stall", {31'd0, bus.stall}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_async_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      exec($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].exp);

    // After the last table op the bench is mid-cycle with a bubble presented.
    @(posedge clk); #1;
    chk("single_valid_after_multi", {31'd0, bus.out_details.is_valid}, 32'd0);

    exec("pre_bubble_add", FN_ADD, 32'd40, 32'd2, 32'd42);
    bus.alu_fn = FN_SUB;
    bus.op_a   = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    chk("bubble_valid", {31'd0, bus.out_details.is_valid}, 32'd0);
    chk("bubble_data_hold", bus.data, 32'd42);

    // Flush during a DIVU at T+10.
    present(FN_DIVU, 32'd1000, 32'd3);
    nv = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus.out_details.is_valid) nv++;
    end
    bus.flush = 1'b1;
    #1;
    chk("flush_stall_low", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    if (bus.out_details.is_valid) nv++;
    chk("flush_no_valid", nv, 0);
    exec("post_flush_add", FN_ADD, 32'd2, 32'd3, 32'd5);
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_details.is_valid) nv++;
    end
    chk("flush_no_late_result", nv, 0);

    // Flush coinciding with the DONE cycle.
    present(FN_MUL, 32'd6, 32'd7);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_done_valid", {31'd0, bus.out_details.is_valid}, 32'd0);
    chk("flush_done_data_hold", bus.data, 32'd5);
    bubble();

    // Flush wins over a simultaneous accept.
    present(FN_MUL, 32'd6, 32'd7);
    bus.flush = 1'b1;
    #1;
    chk("flush_accept_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    chk("flush_accept_valid", {31'd0, bus.out_details.is_valid}, 32'd0);
    bubble();
    exec("after_flush_accept", FN_ADD, 32'd1, 32'd1, 32'd2);

    // Asynchronous reset in the middle of a MUL.
    exec("pre_reset_add", FN_ADD, 32'd10, 32'd20, 32'd30);
    present(FN_MUL, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #3 rst_async_n = 1'b0;
    bubble();
    #1;
    chk("midreset_data", bus.data, 32'd0);
    chk("midreset_details", {23'd0, bus.out_details}, 32'd0);
    chk("midreset_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #2 rst_async_n = 1'b1;
    @(posedge clk); #1;
    exec("post_reset_mul", FN_MUL, 32'd9, 32'd9, 32'd81);

    // Random operations against the reference model.
    for (int i = 0; i < 50; i++) begin
      fn = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      exec($sformatf("rand%0d_fn%0d", i, fn), fn, a, b, model(fn, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
